apb_master: RTL and testbench

APB master bridge sitting directly upstream of `apb_slave`. It accepts single read/write commands on a valid/ready request channel and sequences them as APB SETUP/ACCESS transfers. It returns read data and an error flag on a valid/ready response channel. Wait states are supported through PREADY, bounded by a timeout counter.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_wait_counter.sv | 28 ++
 rtl/apb_master.sv | 132 +++++++++++++
 tb/tb_apb_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus width defaults (common with apb_slave) and the
// master sequencing states.
package apb_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apbState_t;

endpackage

// File: rtl/apb_wait_counter.sv
// Counts ACCESS cycles spent with PREADY low; expired flags the cycle that
// would be the TIMEOUT-th such cycle.
module apb_wait_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int cntWidth = $clog2(TIMEOUT + 1);

  logic [cntWidth-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Already TIMEOUT-1 low cycles behind us, so a low PREADY now is the last allowed.
  assign expired = (count == cntWidth'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// APB master bridge: one command at a time sequenced as SETUP/ACCESS, result
// returned on a valid/ready response channel. Every output is a register.
module apb_master
  import apb_pkg::*;
#(
  parameter int addrWidth = ADDR_WIDTH,
  parameter int dataWidth = DATA_WIDTH,
  parameter int TIMEOUT   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESENT,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [addrWidth-1:0] PADDR,
  output logic                 PWRITE,
  output logic                 PSELx,
  output logic                 PENABLE,
  output logic [dataWidth-1:0] PWDATA,
  input  logic [dataWidth-1:0] PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  apbState_t state, nextState;

  logic                 nextCmdReady, nextRspValid, nextRspErr;
  logic                 nextPwrite, nextPsel, nextPenable;
  logic [dataWidth-1:0] nextRspRdata, nextPwdata;
  logic [addrWidth-1:0] nextPaddr;
  logic                 waitExpired;

  apb_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) waitCounter (
    .clock   (PCLK),
    .reset   (PRESENT),
    .clear   ((state == IDLE) && cmd_valid),
    .enable  ((state == ACCESS) && !PREADY),
    .expired (waitExpired)
  );

  always_ff @(posedge PCLK) begin
    if (PRESENT) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWDATA    <= '0;
    end else begin
      state     <= nextState;
      cmd_ready <= nextCmdReady;
      rsp_valid <= nextRspValid;
      rsp_rdata <= nextRspRdata;
      rsp_err   <= nextRspErr;
      PADDR     <= nextPaddr;
      PWRITE    <= nextPwrite;
      PSELx     <= nextPsel;
      PENABLE   <= nextPenable;
      PWDATA    <= nextPwdata;
    end
  end

  // Next-cycle values for every registered output; anything not touched holds.
  always_comb begin
    nextState    = state;
    nextCmdReady = cmd_ready;
    nextRspValid = rsp_valid;
    nextRspRdata = rsp_rdata;
    nextRspErr   = rsp_err;
    nextPaddr    = PADDR;
    nextPwrite   = PWRITE;
    nextPsel     = PSELx;
    nextPenable  = PENABLE;
    nextPwdata   = PWDATA;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          nextState    = SETUP;
          nextCmdReady = 1'b0;
          nextPaddr    = cmd_addr;
          nextPwrite   = cmd_write;
          nextPwdata   = cmd_wdata;
          nextPsel     = 1'b1;
        end
      end
      SETUP: begin
        nextState   = ACCESS;
        nextPenable = 1'b1;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the timeout cycle still wins.
        if (PREADY) begin
          nextState    = RESP;
          nextRspValid = 1'b1;
          nextRspRdata = PWRITE ? '0 : PRDATA;
          nextRspErr   = PSLVERR;
          nextPsel     = 1'b0;
          nextPenable  = 1'b0;
        end else if (waitExpired) begin
          nextState    = RESP;
          nextRspValid = 1'b1;
          nextRspRdata = '0;
          nextRspErr   = 1'b1;
          nextPsel     = 1'b0;
          nextPenable  = 1'b0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          nextState    = IDLE;
          nextRspValid = 1'b0;
          nextCmdReady = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: the bench plays the APB slave (a small
// memory) and predicts each response from the transaction, wait count and error.
module tb_apb_master;

  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic          PCLK = 1'b0;
  logic          PRESENT;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PWRITE, PSELx, PENABLE;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] slaveMem [256];

  apb_master #(
    .addrWidth (AW),
    .dataWidth (DW),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .PCLK      (PCLK),
    .PRESENT   (PRESENT),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic fail(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    errors++;
    $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
  endtask

  task automatic checkIdleOutputs(input string name);
    checks++;
    if ({cmd_ready, rsp_valid, PSELx, PENABLE} !== 4'b1000)
      fail({name, " ctrl"}, {28'd0, cmd_ready, rsp_valid, PSELx, PENABLE}, 32'h8);
  endtask

  // Drives one command and follows it cycle by cycle. waits = PREADY-low
  // cycles before PREADY rises; waits >= TIMEOUT means PREADY never rises.
  task automatic runTxn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int waits, input logic slverr, input int rspHold, input string name);
    int            accLen;
    logic          timedOut;
    logic [DW-1:0] expRdata;
    logic          expErr;
    timedOut = (waits >= TIMEOUT);
    accLen   = timedOut ? TIMEOUT : waits + 1;
    expRdata = (wr || timedOut) ? '0 : slaveMem[addr];
    expErr   = timedOut || slverr;

    checks++;
    if (cmd_ready !== 1'b1) fail({name, " cmd_ready idle"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    rsp_ready = 1'b0; PREADY = 1'b0;

    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_write = ~wr;
    checks++;
    if ({PSELx, PENABLE, cmd_ready, rsp_valid} !== 4'b1000)
      fail({name, " setup ctrl"}, {28'd0, PSELx, PENABLE, cmd_ready, rsp_valid}, 32'h8);
    checks++;
    if (PADDR !== addr || PWRITE !== wr)
      fail({name, " setup addr/dir"}, {23'd0, PWRITE, PADDR}, {23'd0, wr, addr});
    if (wr) begin
      checks++;
      if (PWDATA !== wdata) fail({name, " setup pwdata"}, PWDATA, wdata);
    end

    for (int i = 0; i < accLen; i++) begin
      @(negedge PCLK);
      checks++;
      if ({PSELx, PENABLE, cmd_ready, rsp_valid} !== 4'b1100)
        fail({name, " access ctrl"}, {28'd0, PSELx, PENABLE, cmd_ready, rsp_valid}, 32'hC);
      checks++;
      if (PADDR !== addr || PWRITE !== wr || (wr && PWDATA !== wdata))
        fail({name, " access stable"}, {23'd0, PWRITE, PADDR}, {23'd0, wr, addr});
      if (i == waits) begin
        PREADY  = 1'b1;
        PRDATA  = slaveMem[addr];
        PSLVERR = slverr;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom);
      end
    end
    if (wr && !expErr) slaveMem[addr] = wdata;

    @(negedge PCLK);
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
    for (int h = 0; h <= rspHold; h++) begin
      checks++;
      if ({rsp_valid, cmd_ready, PSELx, PENABLE} !== 4'b1000)
        fail({name, " resp ctrl"}, {28'd0, rsp_valid, cmd_ready, PSELx, PENABLE}, 32'h8);
      checks++;
      if (rsp_rdata !== expRdata) fail({name, " rsp_rdata"}, rsp_rdata, expRdata);
      checks++;
      if (rsp_err !== expErr) fail({name, " rsp_err"}, {31'd0, rsp_err}, {31'd0, expErr});
      if (h == rspHold) rsp_ready = 1'b1;
      @(negedge PCLK);
    end
    rsp_ready = 1'b0;
    checkIdleOutputs({name, " after resp"});
  endtask

  task automatic test_reset;
    PRESENT = 1'b1;
    repeat (2) @(negedge PCLK);
    checkIdleOutputs("reset");
    checks++;
    if ({rsp_rdata, rsp_err, PADDR, PWRITE, PWDATA} !== '0)
      fail("reset data", rsp_rdata ^ PWDATA, 32'd0);
    PRESENT = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_directed;
    runTxn(1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0, 0, "write_0x10");
    runTxn(1'b0, 8'h10, 32'h0, 0, 1'b0, 0, "read_0x10");
    slaveMem[8'h20] = 32'h12345678;
    runTxn(1'b0, 8'h20, 32'h0, 3, 1'b0, 0, "read_wait3");
    runTxn(1'b0, 8'h20, 32'h0, TIMEOUT, 1'b0, 1, "timeout");
    runTxn(1'b0, 8'h20, 32'h0, TIMEOUT - 1, 1'b0, 0, "ready_at_timeout");
    runTxn(1'b1, 8'h30, 32'hCAFEF00D, 0, 1'b1, 5, "pslverr_write");
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      logic          wr;
      logic [AW-1:0] addr;
      int            waits;
      wr    = 1'($urandom);
      addr  = AW'($urandom_range(0, 7));
      waits = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TIMEOUT + 2) : $urandom_range(0, 3);
      runTxn(wr, addr, $urandom, waits, ($urandom_range(0, 7) == 0), $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] wdata;
    wdata     = $urandom;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h44; cmd_wdata = wdata;
    rsp_ready = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cmd_ready !== (i % 4 == 0)) fail("b2b cmd_ready", {31'd0, cmd_ready}, {31'd0, i % 4 == 0});
      checks++;
      if (rsp_valid !== (i % 4 == 3)) fail("b2b rsp_valid", {31'd0, rsp_valid}, {31'd0, i % 4 == 3});
      @(negedge PCLK);
    end
    cmd_valid = 1'b0;
    repeat (4) @(negedge PCLK);
    rsp_ready = 1'b0; PREADY = 1'b0;
    slaveMem[8'h44] = wdata;
    runTxn(1'b0, 8'h44, 32'h0, 0, 1'b0, 0, "b2b_readback");
  endtask

  task automatic test_reset_in_access;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h55; PREADY = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++;
    if (PENABLE !== 1'b1) fail("pre-reset access", {31'd0, PENABLE}, 32'd1);
    PRESENT = 1'b1;
    @(negedge PCLK);
    PRESENT = 1'b0; PREADY = 1'b1;
    checkIdleOutputs("reset_in_access");
    checks++;
    if ({rsp_rdata, rsp_err, PADDR, PWRITE, PWDATA} !== '0)
      fail("reset_in_access data", rsp_rdata ^ PWDATA, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      checkIdleOutputs("no rsp after reset");
    end
    PREADY = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) slaveMem[a] = $urandom;
    PRESENT = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    @(negedge PCLK);
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_in_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
